// File: rtl/seq_alu.sv
// seq_alu: clocked, width-parametrised ALU with internally held FLAG/OVERFLOW
// status and two multi-cycle O-type operations (shift-add MUL, ROTL_N).
//
// Ports:
//   CLK       rising-edge clock
//   RESET_N   synchronous active-low reset
//   START     launch operation on OP/FUNC/INPUTA/INPUTB (ignored while BUSY)
//   OP, FUNC  opcode and O-type function select
//   INPUTA/B  operands; INPUTB[SHW-1:0] is the ROTL_N amount
//   BUSY      multi-cycle operation in progress
//   DONE      one-cycle pulse: OUT/OUT_HI/FLAG/OVERFLOW updated this cycle
//   OUT       result (low half of MUL product)
//   OUT_HI    high half of MUL product, 0 after any other op
//   FLAG      registered compare flag
//   OVERFLOW  registered carry/borrow/shift-out bit
module seq_alu #(
  parameter int WIDTH = 8,
  // Derived rotate-amount width; leave at its default.
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             START,
  input  logic [2:0]       OP,
  input  logic [2:0]       FUNC,
  input  logic [WIDTH-1:0] INPUTA,
  input  logic [WIDTH-1:0] INPUTB,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] OUT,
  output logic [WIDTH-1:0] OUT_HI,
  output logic             FLAG,
  output logic             OVERFLOW
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_LW    = 3'b000;
  localparam logic [2:0] OP_SW    = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_CEQ   = 3'b100;
  localparam logic [2:0] OP_CLT   = 3'b101;
  localparam logic [2:0] OP_SEI   = 3'b110;
  localparam logic [2:0] OP_OTYPE = 3'b111;

  localparam logic [2:0] FN_SHL_X = 3'b000;
  localparam logic [2:0] FN_SHL_F = 3'b001;
  localparam logic [2:0] FN_SHL_O = 3'b010;
  localparam logic [2:0] FN_SHR_X = 3'b011;
  localparam logic [2:0] FN_SHR_F = 3'b100;
  localparam logic [2:0] FN_SHR_O = 3'b101;
  localparam logic [2:0] FN_MUL   = 3'b110;
  localparam logic [2:0] FN_ROTL  = 3'b111;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_ROT} state_t;

  state_t           state, state_nxt;
  logic             done_nxt;
  logic [WIDTH-1:0] out_nxt, out_hi_nxt;
  logic             flag_nxt, ovf_nxt;

  // Multi-cycle working registers (data only, no reset needed)
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] work_a, work_a_nxt;   // multiplicand, or value being rotated
  logic [WIDTH-1:0] acc_hi, acc_hi_nxt;   // upper half of the product accumulator
  logic [WIDTH-1:0] mul_lo, mul_lo_nxt;   // multiplier, shifted out as product bits shift in

  logic [WIDTH:0]   add_sum, sub_diff, step_sum;
  logic [SHW-1:0]   rot_n;

  assign BUSY  = (state != ST_IDLE);
  assign rot_n = INPUTB[SHW-1:0];

  assign add_sum  = {1'b0, INPUTA} + {1'b0, INPUTB} + {{WIDTH{1'b0}}, OVERFLOW};
  // Top bit of the (WIDTH+1)-bit difference is the borrow out.
  assign sub_diff = {1'b0, INPUTA} - {1'b0, INPUTB} - {{WIDTH{1'b0}}, OVERFLOW};
  // One shift-add step: add multiplicand when the current multiplier LSB is set.
  assign step_sum = {1'b0, acc_hi} + (mul_lo[0] ? {1'b0, work_a} : {(WIDTH+1){1'b0}});

  always_comb begin
    state_nxt  = state;
    done_nxt   = 1'b0;
    out_nxt    = OUT;
    out_hi_nxt = OUT_HI;
    flag_nxt   = FLAG;
    ovf_nxt    = OVERFLOW;
    cnt_nxt    = cnt;
    work_a_nxt = work_a;
    acc_hi_nxt = acc_hi;
    mul_lo_nxt = mul_lo;

    case (state)
      ST_IDLE: begin
        if (START) begin
          if (OP == OP_OTYPE && FUNC == FN_MUL) begin
            work_a_nxt = INPUTA;
            mul_lo_nxt = INPUTB;
            acc_hi_nxt = '0;
            cnt_nxt    = CW'(WIDTH);
            state_nxt  = ST_MUL;
          end else if (OP == OP_OTYPE && FUNC == FN_ROTL && rot_n != '0) begin
            work_a_nxt = INPUTA;
            cnt_nxt    = {{(CW-SHW){1'b0}}, rot_n};
            state_nxt  = ST_ROT;
          end else begin
            done_nxt   = 1'b1;
            out_hi_nxt = '0;
            case (OP)
              OP_LW, OP_SW: begin
                out_nxt = INPUTB;
                ovf_nxt = 1'b0;
              end
              OP_SEI: begin
                out_nxt = INPUTA;
                ovf_nxt = 1'b0;
              end
              OP_ADD: {ovf_nxt, out_nxt} = add_sum;
              OP_SUB: {ovf_nxt, out_nxt} = sub_diff;
              OP_CEQ: begin
                flag_nxt = (INPUTA == INPUTB);
                out_nxt  = '0;
                ovf_nxt  = 1'b0;
              end
              OP_CLT: begin
                flag_nxt = (INPUTA < INPUTB);
                out_nxt  = '0;
                ovf_nxt  = 1'b0;
              end
              default: begin
                case (FUNC)
                  FN_SHL_X: {ovf_nxt, out_nxt} = {INPUTA, 1'b0};
                  FN_SHL_F: {ovf_nxt, out_nxt} = {INPUTA, FLAG};
                  FN_SHL_O: {ovf_nxt, out_nxt} = {INPUTA, OVERFLOW};
                  FN_SHR_X: {out_nxt, ovf_nxt} = {1'b0, INPUTA};
                  FN_SHR_F: {out_nxt, ovf_nxt} = {FLAG, INPUTA};
                  FN_SHR_O: {out_nxt, ovf_nxt} = {OVERFLOW, INPUTA};
                  default: begin
                    // Only ROTL_N with a zero amount reaches here: pass A through.
                    out_nxt = INPUTA;
                    ovf_nxt = 1'b0;
                  end
                endcase
              end
            endcase
          end
        end
      end

      ST_MUL: begin
        acc_hi_nxt = step_sum[WIDTH:1];
        mul_lo_nxt = {step_sum[0], mul_lo[WIDTH-1:1]};
        cnt_nxt    = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          done_nxt   = 1'b1;
          out_nxt    = mul_lo_nxt;
          out_hi_nxt = acc_hi_nxt;
          ovf_nxt    = (acc_hi_nxt != '0);
          state_nxt  = ST_IDLE;
        end
      end

      ST_ROT: begin
        work_a_nxt = {work_a[WIDTH-2:0], work_a[WIDTH-1]};
        cnt_nxt    = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          done_nxt   = 1'b1;
          out_nxt    = work_a_nxt;
          out_hi_nxt = '0;
          ovf_nxt    = work_a[WIDTH-1];
          state_nxt  = ST_IDLE;
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  // Control and architectural outputs
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state    <= ST_IDLE;
      DONE     <= 1'b0;
      OUT      <= '0;
      OUT_HI   <= '0;
      FLAG     <= 1'b0;
      OVERFLOW <= 1'b0;
    end else begin
      state    <= state_nxt;
      DONE     <= done_nxt;
      OUT      <= out_nxt;
      OUT_HI   <= out_hi_nxt;
      FLAG     <= flag_nxt;
      OVERFLOW <= ovf_nxt;
    end
  end

  // Working registers; only meaningful while BUSY, so left unreset
  always_ff @(posedge CLK) begin
    cnt    <= cnt_nxt;
    work_a <= work_a_nxt;
    acc_hi <= acc_hi_nxt;
    mul_lo <= mul_lo_nxt;
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed-vector bench for seq_alu: an 8-bit instance for most scenarios and
// a 16-bit instance for the wide multiply.
module tb_seq_alu;

  localparam logic [2:0] OP_LW = 3'b000, OP_ADD = 3'b010, OP_SUB = 3'b011,
                         OP_CEQ = 3'b100, OP_CLT = 3'b101, OP_SEI = 3'b110,
                         OP_O = 3'b111;
  localparam logic [2:0] FN_SHL_F = 3'b001, FN_SHR_X = 3'b011, FN_SHR_F = 3'b100,
                         FN_SHR_O = 3'b101, FN_MUL = 3'b110, FN_ROTL = 3'b111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, start16 = 1'b0;
  logic [2:0]  op = '0, func = '0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy8, done8, flag8, ovf8;
  logic [7:0]  out8, hi8;
  logic        busy16, done16, flag16, ovf16;
  logic [15:0] out16, hi16;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(8)) u8 (
    .CLK(clk), .RESET_N(rst_n), .START(start), .OP(op), .FUNC(func),
    .INPUTA(a8), .INPUTB(b8), .BUSY(busy8), .DONE(done8), .OUT(out8),
    .OUT_HI(hi8), .FLAG(flag8), .OVERFLOW(ovf8)
  );

  seq_alu #(.WIDTH(16)) u16 (
    .CLK(clk), .RESET_N(rst_n), .START(start16), .OP(op), .FUNC(func),
    .INPUTA(a16), .INPUTB(b16), .BUSY(busy16), .DONE(done16), .OUT(out16),
    .OUT_HI(hi16), .FLAG(flag16), .OVERFLOW(ovf16)
  );

  typedef struct {
    logic [2:0] op;
    logic [2:0] fn;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] out;
    logic       f;
    logic       v;
  } vec_t;

  // Expected values worked by hand, each depending on the F/V left by the row above.
  vec_t vecs [0:13] = '{
    '{OP_ADD, 3'd0,     8'hF0, 8'h20, 8'h10, 1'b0, 1'b1},  // carry out
    '{OP_SUB, 3'd0,     8'h05, 8'h07, 8'hFD, 1'b0, 1'b1},  // 5-7-1, borrow
    '{OP_CLT, 3'd0,     8'h03, 8'h05, 8'h00, 1'b1, 1'b0},
    '{OP_O,   FN_SHL_F, 8'h80, 8'h00, 8'h01, 1'b1, 1'b1},  // fill from F=1
    '{OP_LW,  3'd0,     8'h11, 8'h5A, 8'h5A, 1'b1, 1'b0},
    '{OP_CEQ, 3'd0,     8'h05, 8'h06, 8'h00, 1'b0, 1'b0},
    '{OP_SEI, 3'd0,     8'h3C, 8'h00, 8'h3C, 1'b0, 1'b0},
    '{OP_O,   FN_SHR_X, 8'h03, 8'h00, 8'h01, 1'b0, 1'b1},
    '{OP_ADD, 3'd0,     8'h01, 8'h01, 8'h03, 1'b0, 1'b0},  // carry-in from V=1
    '{OP_O,   FN_SHR_X, 8'h03, 8'h00, 8'h01, 1'b0, 1'b1},
    '{OP_O,   FN_SHR_O, 8'h02, 8'h00, 8'h81, 1'b0, 1'b0},  // fill from V=1
    '{OP_CEQ, 3'd0,     8'h07, 8'h07, 8'h00, 1'b1, 1'b0},
    '{OP_O,   FN_SHR_F, 8'h04, 8'h00, 8'h82, 1'b1, 1'b0},  // fill from F=1
    '{OP_SUB, 3'd0,     8'h09, 8'h04, 8'h05, 1'b1, 1'b0}   // no borrow
  };

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present an op for one clock edge; returns at the falling edge after it.
  task automatic issue8(input logic [2:0] o, input logic [2:0] f,
                        input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    op = o; func = f; a8 = a; b8 = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Count cycles from the START edge until DONE (bounded); optionally pokes a
  // stray START while busy.
  task automatic wait_done8(input bit poke, output int lat, output int bsy);
    lat = 1;
    bsy = 0;
    while (done8 !== 1'b1 && lat < 64) begin
      if (busy8 === 1'b1) bsy++;
      if (poke && lat == 3) begin
        op = OP_ADD; func = 3'd0; a8 = 8'h01; b8 = 8'h01; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
  endtask

  task automatic run_vec(input int i);
    issue8(vecs[i].op, vecs[i].fn, vecs[i].a, vecs[i].b);
    chk($sformatf("v%0d_done", i), 32'(done8), 32'd1);
    chk($sformatf("v%0d_out", i), 32'(out8), 32'(vecs[i].out));
    chk($sformatf("v%0d_hi", i), 32'(hi8), 32'd0);
    chk($sformatf("v%0d_flag", i), 32'(flag8), 32'(vecs[i].f));
    chk($sformatf("v%0d_ovf", i), 32'(ovf8), 32'(vecs[i].v));
  endtask

  initial begin
    int lat, bsy, extra;

    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    chk("rst_out", 32'(out8), 32'd0);
    chk("rst_hi", 32'(hi8), 32'd0);
    chk("rst_flag", 32'(flag8), 32'd0);
    chk("rst_ovf", 32'(ovf8), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) run_vec(i);

    // MUL 0xFF*0xFF = 0xFE01, with a stray START while busy
    issue8(OP_O, FN_MUL, 8'hFF, 8'hFF);
    wait_done8(1'b1, lat, bsy);
    chk("mul_lat", 32'(lat), 32'd9);
    chk("mul_busy_cycles", 32'(bsy), 32'd8);
    chk("mul_out", 32'(out8), 32'h01);
    chk("mul_hi", 32'(hi8), 32'hFE);
    chk("mul_ovf", 32'(ovf8), 32'd1);
    chk("mul_flag", 32'(flag8), 32'd1);
    chk("mul_busy_at_done", 32'(busy8), 32'd0);
    @(negedge clk);
    chk("mul_no_queued_done", 32'(done8), 32'd0);
    chk("mul_out_hold", 32'(out8), 32'h01);

    // ROTL_N 0x81 by 3 -> 0x0C, last bit out 0; OUT_HI cleared after MUL
    issue8(OP_O, FN_ROTL, 8'h81, 8'h03);
    wait_done8(1'b0, lat, bsy);
    chk("rot3_lat", 32'(lat), 32'd4);
    chk("rot3_out", 32'(out8), 32'h0C);
    chk("rot3_ovf", 32'(ovf8), 32'd0);
    chk("rot3_hi", 32'(hi8), 32'd0);

    // ROTL_N 0x81 by 1 -> 0x03, last bit out 1
    issue8(OP_O, FN_ROTL, 8'h81, 8'h01);
    wait_done8(1'b0, lat, bsy);
    chk("rot1_lat", 32'(lat), 32'd2);
    chk("rot1_out", 32'(out8), 32'h03);
    chk("rot1_ovf", 32'(ovf8), 32'd1);

    // B=8 truncates to amount 0: single-cycle pass-through
    issue8(OP_O, FN_ROTL, 8'h81, 8'h08);
    wait_done8(1'b0, lat, bsy);
    chk("rot0_lat", 32'(lat), 32'd1);
    chk("rot0_out", 32'(out8), 32'h81);
    chk("rot0_ovf", 32'(ovf8), 32'd0);

    for (int i = 4; i < 14; i++) run_vec(i);

    // Reset in the 4th cycle of a MUL aborts it
    issue8(OP_O, FN_MUL, 8'h0F, 8'h0F);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy8), 32'd0);
    chk("abort_done", 32'(done8), 32'd0);
    chk("abort_out", 32'(out8), 32'd0);
    chk("abort_hi", 32'(hi8), 32'd0);
    chk("abort_flag", 32'(flag8), 32'd0);
    chk("abort_ovf", 32'(ovf8), 32'd0);
    rst_n = 1'b1;
    extra = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done8 === 1'b1 || busy8 === 1'b1) extra++;
    end
    chk("abort_no_activity", 32'(extra), 32'd0);
    issue8(OP_ADD, 3'd0, 8'h01, 8'h01);
    chk("post_abort_done", 32'(done8), 32'd1);
    chk("post_abort_out", 32'(out8), 32'h02);
    chk("post_abort_ovf", 32'(ovf8), 32'd0);

    // 16-bit MUL 0x1234*0x0010 = 0x0001_2340
    @(negedge clk);
    op = OP_O; func = FN_MUL; a16 = 16'h1234; b16 = 16'h0010; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    a16 = 16'hFFFF; b16 = 16'hFFFF;
    lat = 1;
    while (done16 !== 1'b1 && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    chk("mul16_lat", 32'(lat), 32'd17);
    chk("mul16_out", 32'(out16), 32'h2340);
    chk("mul16_hi", 32'(hi16), 32'h0001);
    chk("mul16_ovf", 32'(ovf16), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
